// File: rtl/hv_alu_pkg.sv
// Shared definitions for the hypervector ALU PE, its sequencer and the encoder decoder.
package hv_alu_pkg;

  // Element-wise ALU operations, encoded as on the command bus.
  typedef enum logic [1:0] {
    ALU_XOR    = 2'd0,
    ALU_PASS_A = 2'd1,
    ALU_PASS_B = 2'd2,
    ALU_CSHIFT = 2'd3
  } alu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hv_alu_pe.sv
// Combinational hypervector ALU: XOR, pass A, pass B, circular shift right.
module hv_alu_pe
  import hv_alu_pkg::*;
#(
  parameter int HVDimension = 512,
  parameter int NumOps      = 4,
  parameter int MaxShiftAmt = 128,
  parameter int NumOpsWidth = $clog2(NumOps),
  parameter int ShiftWidth  = $clog2(MaxShiftAmt)
) (
  input  logic [HVDimension-1:0] a_i,
  input  logic [HVDimension-1:0] b_i,
  input  logic [NumOpsWidth-1:0] op_i,
  input  logic [ShiftWidth-1:0]  shift_i,
  output logic [HVDimension-1:0] res_o
);

  logic [31:0]              shift_mod;
  logic [2*HVDimension-1:0] rot_wide;

  // Rotation is taken modulo the vector width, so any shift field value is legal.
  assign shift_mod = 32'(shift_i) % 32'(HVDimension);
  assign rot_wide  = {a_i, a_i} >> shift_mod;

  // Operation select.
  always_comb begin
    // NOTE: res_o gets a default first so no path through the case leaves it unassigned (no latch).
    res_o = a_i;
    case (alu_op_e'(op_i))
      ALU_XOR:    res_o = a_i ^ b_i;
      ALU_PASS_A: res_o = a_i;
      ALU_PASS_B: res_o = b_i;
      ALU_CSHIFT: res_o = rot_wide[HVDimension-1:0];
      default:    res_o = a_i;
    endcase
  end

endmodule

// File: rtl/hv_alu_ctrl.sv
// Iterative sequencer: loads A into an accumulator, applies acc = ALU(acc, B) N times,
// then holds the result under valid/ready backpressure.
module hv_alu_ctrl
  import hv_alu_pkg::*;
#(
  parameter int HVDimension = 512,
  parameter int NumOps      = 4,
  parameter int MaxShiftAmt = 128,
  parameter int MaxIter     = 255,
  parameter int NumOpsWidth = $clog2(NumOps),
  parameter int ShiftWidth  = $clog2(MaxShiftAmt),
  parameter int IterWidth   = $clog2(MaxIter + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [NumOpsWidth-1:0] cmd_op_i,
  input  logic [ShiftWidth-1:0]  cmd_shift_amt_i,
  input  logic [IterWidth-1:0]   cmd_iter_i,
  input  logic [HVDimension-1:0] A_i,
  input  logic [HVDimension-1:0] B_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [HVDimension-1:0] res_o,
  output logic                   busy_o
);

  ctrl_state_e            state_q;
  logic [HVDimension-1:0] acc_q, acc_d;
  logic [HVDimension-1:0] b_q;
  logic [NumOpsWidth-1:0] op_q;
  logic [ShiftWidth-1:0]  shift_q;
  logic [IterWidth-1:0]   cnt_q;
  logic                   res_valid_q;
  logic                   busy_q;

  // The ALU only ever sees registered operands, so one iteration costs exactly one cycle.
  hv_alu_pe #(
    .HVDimension(HVDimension),
    .NumOps     (NumOps),
    .MaxShiftAmt(MaxShiftAmt)
  ) u_pe (
    .a_i    (acc_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .shift_i(shift_q),
    .res_o  (acc_d)
  );

  // Ready depends only on state and the abort, never on cmd_valid_i.
  assign cmd_ready_o = (state_q == IDLE) && !clr_i;
  assign res_valid_o = res_valid_q;
  assign busy_o      = busy_q;
  assign res_o       = acc_q;

  // Sequencer FSM with accumulator, iteration counter, operand latches and registered flags.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      op_q        <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr_i) begin
      // Abort beats any simultaneous accept or result handshake; acc is kept but stale.
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            acc_q   <= A_i;
            b_q     <= B_i;
            op_q    <= cmd_op_i;
            shift_q <= cmd_shift_amt_i;
            cnt_q   <= cmd_iter_i;
            busy_q  <= 1'b1;
            if (cmd_iter_i != '0) begin
              state_q <= EXEC;
            end else begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - IterWidth'(1);
          if (cnt_q == IterWidth'(1)) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
